// File: rtl/sfx_pkg.sv
// Shared constants and types for the sound-effect sequencer and its note table.
package sfx_pkg;

  localparam logic [2:0] NOTE_SIL = 3'd0;
  localparam logic [2:0] NOTE_C   = 3'd1;
  localparam logic [2:0] NOTE_D   = 3'd2;
  localparam logic [2:0] NOTE_E   = 3'd3;
  localparam logic [2:0] NOTE_G   = 3'd4;

  // Sequence ids double as priorities: a larger id wins.
  localparam logic [1:0] SEQ_NONE   = 2'd0;
  localparam logic [1:0] SEQ_PADDLE = 2'd1;
  localparam logic [1:0] SEQ_BRICK  = 2'd2;
  localparam logic [1:0] SEQ_LOSE   = 2'd3;

  localparam int unsigned LEN_PADDLE = 1;
  localparam int unsigned LEN_BRICK  = 2;
  localparam int unsigned LEN_LOSE   = 4;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } sfx_state_t;

endpackage

// File: rtl/sfx_note_rom.sv
// Combinational note table: (sequence, entry index) -> note code, duration in ms, last flag.
module sfx_note_rom
  import sfx_pkg::*;
(
  input  logic [1:0] seq_id,
  input  logic [1:0] idx,
  output logic [2:0] note,
  output logic [7:0] dur_ms,
  output logic       last
);

  always_comb begin
    note   = NOTE_SIL;
    dur_ms = 8'd0;
    last   = 1'b1;
    case (seq_id)
      SEQ_PADDLE: begin
        note   = NOTE_G;
        dur_ms = 8'd40;
        last   = (idx == 2'(LEN_PADDLE - 1));
      end
      SEQ_BRICK: begin
        note   = (idx == 2'd0) ? NOTE_E : NOTE_G;
        dur_ms = 8'd30;
        last   = (idx == 2'(LEN_BRICK - 1));
      end
      SEQ_LOSE: begin
        case (idx)
          2'd0:    begin note = NOTE_G; dur_ms = 8'd80;  end
          2'd1:    begin note = NOTE_E; dur_ms = 8'd80;  end
          2'd2:    begin note = NOTE_D; dur_ms = 8'd80;  end
          default: begin note = NOTE_C; dur_ms = 8'd160; end
        endcase
        last = (idx == 2'(LEN_LOSE - 1));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Game sound-effect sequencer: turns event pulses into timed note-code sequences.
// Define SFX_QUEUE_EN to keep one pending ignored event and play it after the current one.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evt_paddle,
  input  logic       evt_brick,
  input  logic       evt_lose,
  output logic [2:0] note,
  output logic       busy,
  output logic [1:0] seq_id
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] GAP_LEN   = 16'(GAP_MS);

  sfx_state_t  state;
  logic [1:0]  idx;
  logic [15:0] cyc_cnt;
  logic [15:0] ms_cnt;
  logic [7:0]  dur_q;
  logic        last_q;

  logic [1:0]  evt_pri;
  logic [1:0]  start_seq;
  logic        start;
  logic        advance;
  logic        tick_done;
  logic        note_done;
  logic        gap_done;
  logic        seq_end;
  logic [1:0]  rom_seq;
  logic [1:0]  rom_idx;
  logic [2:0]  rom_note;
  logic [7:0]  rom_dur;
  logic        rom_last;

`ifdef SFX_QUEUE_EN
  logic [1:0]  pend;
`endif

  always_comb begin
    evt_pri = SEQ_NONE;
    if (evt_lose)        evt_pri = SEQ_LOSE;
    else if (evt_brick)  evt_pri = SEQ_BRICK;
    else if (evt_paddle) evt_pri = SEQ_PADDLE;
  end

  assign tick_done = (cyc_cnt == TICK_LAST);
  assign note_done = tick_done && ((ms_cnt + 16'd1) == {8'h00, dur_q});
  assign gap_done  = tick_done && ((ms_cnt + 16'd1) == GAP_LEN);
  assign seq_end   = (state == NOTE) && note_done && last_q;

  // An event on the ending edge is handled as if already idle; pending waits one idle cycle.
  always_comb begin
    start_seq = SEQ_NONE;
    if (state == IDLE || seq_end) start_seq = evt_pri;
    else if (evt_pri > seq_id)    start_seq = evt_pri;
`ifdef SFX_QUEUE_EN
    if (state == IDLE && pend > start_seq) start_seq = pend;
`endif
  end

  assign start   = (start_seq != SEQ_NONE);
  assign advance = !start &&
                   (((state == NOTE) && note_done && !last_q && (GAP_MS == 0)) ||
                    ((state == GAP) && gap_done));

  // One table lookup serves both a fresh start and the step to the next entry.
  assign rom_seq = start ? start_seq : seq_id;
  assign rom_idx = start ? 2'd0 : idx + 2'd1;

  sfx_note_rom u_rom (
    .seq_id (rom_seq),
    .idx    (rom_idx),
    .note   (rom_note),
    .dur_ms (rom_dur),
    .last   (rom_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      cyc_cnt <= '0;
      ms_cnt  <= '0;
      dur_q   <= '0;
      last_q  <= 1'b0;
      note    <= NOTE_SIL;
      busy    <= 1'b0;
      seq_id  <= SEQ_NONE;
    end else begin
      if (state != IDLE) begin
        if (tick_done) begin
          cyc_cnt <= '0;
          ms_cnt  <= ms_cnt + 16'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 16'd1;
        end
      end
      if (start || advance) begin
        state   <= NOTE;
        seq_id  <= rom_seq;
        idx     <= rom_idx;
        note    <= rom_note;
        dur_q   <= rom_dur;
        last_q  <= rom_last;
        busy    <= 1'b1;
        cyc_cnt <= '0;
        ms_cnt  <= '0;
      end else if (state == NOTE && note_done) begin
        note    <= NOTE_SIL;
        cyc_cnt <= '0;
        ms_cnt  <= '0;
        if (last_q) begin
          state  <= IDLE;
          busy   <= 1'b0;
          seq_id <= SEQ_NONE;
          idx    <= '0;
        end else begin
          state <= GAP;
        end
      end
    end
  end

`ifdef SFX_QUEUE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= SEQ_NONE;
    end else if (start) begin
      if (pend <= start_seq) pend <= SEQ_NONE;
    end else if (state != IDLE && evt_pri > pend) begin
      pend <= evt_pri;
    end
  end
`endif

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV=4, GAP_MS=1 (1 ms = 4 cycles).
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       evt_paddle;
  logic       evt_brick;
  logic       evt_lose;
  logic [2:0] note;
  logic       busy;
  logic [1:0] seq_id;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sfx_sequencer #(.TICK_DIV(4), .GAP_MS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .evt_paddle (evt_paddle),
    .evt_brick  (evt_brick),
    .evt_lose   (evt_lose),
    .note       (note),
    .busy       (busy),
    .seq_id     (seq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compares {note,busy,seq_id} once per cycle for n cycles, stepping past each edge.
  task automatic run(input string tag, input logic [2:0] n_exp, input logic b_exp,
                     input logic [1:0] s_exp, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), {26'd0, note, busy, seq_id},
            {26'd0, n_exp, b_exp, s_exp});
      @(posedge clk);
      #1;
    end
  endtask

  // m = {lose, brick, paddle}; pulse is sampled on the next rising edge.
  task automatic pulse(input logic [2:0] m);
    {evt_lose, evt_brick, evt_paddle} = m;
    @(posedge clk);
    #1;
    {evt_lose, evt_brick, evt_paddle} = 3'b000;
  endtask

  task automatic lose_tail(input string tag);
    run({tag, "_gap1"}, 3'd0, 1'b1, 2'd3, 4);
    run({tag, "_e"},    3'd3, 1'b1, 2'd3, 320);
    run({tag, "_gap2"}, 3'd0, 1'b1, 2'd3, 4);
    run({tag, "_d"},    3'd2, 1'b1, 2'd3, 320);
    run({tag, "_gap3"}, 3'd0, 1'b1, 2'd3, 4);
    run({tag, "_c"},    3'd1, 1'b1, 2'd3, 640);
    run({tag, "_idle"}, 3'd0, 1'b0, 2'd0, 3);
  endtask

  initial begin
    reset = 1'b1;
    {evt_lose, evt_brick, evt_paddle} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {29'd0, note, busy, seq_id} , 32'd0);
    reset = 1'b0;
    run("post_reset", 3'd0, 1'b0, 2'd0, 2);

    pulse(3'b001);
    run("paddle_g", 3'd4, 1'b1, 2'd1, 160);
    run("paddle_idle", 3'd0, 1'b0, 2'd0, 5);

    pulse(3'b010);
    run("brick_e", 3'd3, 1'b1, 2'd2, 120);
    run("brick_gap", 3'd0, 1'b1, 2'd2, 4);
    run("brick_g", 3'd4, 1'b1, 2'd2, 120);
    run("brick_idle", 3'd0, 1'b0, 2'd0, 3);

    // Lower-priority paddle at cycle 50 of brick.
    pulse(3'b010);
    run("bp_e1", 3'd3, 1'b1, 2'd2, 49);
    pulse(3'b001);
    run("bp_e2", 3'd3, 1'b1, 2'd2, 70);
    run("bp_gap", 3'd0, 1'b1, 2'd2, 4);
    run("bp_g", 3'd4, 1'b1, 2'd2, 120);
`ifdef SFX_QUEUE_EN
    run("bp_idle1", 3'd0, 1'b0, 2'd0, 1);
    run("bp_queued", 3'd4, 1'b1, 2'd1, 160);
`endif
    run("bp_idle", 3'd0, 1'b0, 2'd0, 5);

    // Lose preempts brick at cycle 50.
    pulse(3'b010);
    run("bl_e", 3'd3, 1'b1, 2'd2, 49);
    pulse(3'b100);
    run("bl_g", 3'd4, 1'b1, 2'd3, 320);
    lose_tail("bl");

    // Simultaneous events: lose wins, nothing else plays afterwards.
    pulse(3'b111);
    run("all_g", 3'd4, 1'b1, 2'd3, 320);
    lose_tail("all");
    run("all_quiet", 3'd0, 1'b0, 2'd0, 10);

    // Event on the ending edge starts immediately.
    pulse(3'b001);
    run("edge_g", 3'd4, 1'b1, 2'd1, 159);
    pulse(3'b010);
    run("edge_e", 3'd3, 1'b1, 2'd2, 120);
    run("edge_gap", 3'd0, 1'b1, 2'd2, 4);
    run("edge_g2", 3'd4, 1'b1, 2'd2, 120);
    run("edge_idle", 3'd0, 1'b0, 2'd0, 3);

    // Asynchronous reset in the middle of the lose sequence's second gap.
    pulse(3'b100);
    run("rst_g", 3'd4, 1'b1, 2'd3, 320);
    run("rst_gap1", 3'd0, 1'b1, 2'd3, 4);
    run("rst_e", 3'd3, 1'b1, 2'd3, 320);
    run("rst_gap2", 3'd0, 1'b1, 2'd3, 2);
    reset = 1'b1;
    #1;
    check("async_rst_note", {29'd0, note}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_seq", {30'd0, seq_id}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    pulse(3'b010);
    run("after_rst_e", 3'd3, 1'b1, 2'd2, 120);
    run("after_rst_gap", 3'd0, 1'b1, 2'd2, 4);
    run("after_rst_g", 3'd4, 1'b1, 2'd2, 120);
    run("after_rst_idle", 3'd0, 1'b0, 2'd0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Game sound-effect sequencer, directly upstream of the note-clock select and sine-ROM tone stage.
- Turns single-cycle game events (paddle hit, brick hit, life lost) into timed sequences of note codes.
- The tone stage maps the current note code to its clock divider, so it no longer takes raw buttons.
- Runs in the 50 MHz system domain.

Parameters:
- TICK_DIV, 50000: system clocks per 1 ms tick (minimum 2).
- GAP_MS, 10: silent gap between consecutive notes of a sequence, in ms ticks. 0 means no gap.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- evt_paddle  in  1  1-cycle pulse: ball hit paddle.
- evt_brick  in  1  1-cycle pulse: ball broke brick.
- evt_lose  in  1  1-cycle pulse: ball lost.
- note  out  3  note code: 0 silent, 1 C, 2 D, 3 E, 4 G.
- busy  out  1  high while a sequence is playing, including its gaps.
- seq_id  out  2  current sequence: 0 none, 1 paddle, 2 brick, 3 lose.

Behaviour:
- Reset: note=0, busy=0, seq_id=0, FSM=IDLE, all counters 0. Reset is asynchronous and overrides everything, including mid-sequence.
- Sequences, as (note, ms):
  - paddle: (G,40).
  - brick: (E,30), (G,30).
  - lose: (G,80), (E,80), (D,80), (C,160).
- Priority: lose > brick > paddle. Simultaneous events are resolved by priority; lower-priority events that cycle are dropped.
- FSM states: IDLE, NOTE, GAP.
  - IDLE: an accepted event at edge t loads seq_id and idx=0. From cycle t+1: state=NOTE, note=table note, busy=1 (registered outputs, 1-cycle latency).
  - NOTE: holds for exactly dur_ms*TICK_DIV cycles. Then, if the entry is last, go to IDLE (note=0, busy=0, seq_id=0). Otherwise go to GAP (note=0) for exactly GAP_MS*TICK_DIV cycles; if GAP_MS=0, skip GAP and go straight to the next NOTE. Leaving GAP increments idx.
  - Cycle counter: 0..TICK_DIV-1, restarts on every state entry. Ms counter counts completed ticks. Both are 16 bits; ms durations must not exceed 255.
- Preemption while busy:
  - A strictly higher-priority event restarts immediately with the new sequence at idx 0 (new note visible at t+1; the remainder of the old sequence is discarded).
  - An equal- or lower-priority event is ignored.
- An event on the same edge a sequence ends is treated as arriving in IDLE and is accepted; there is no dead cycle.
- All outputs are registered and glitch-free, because the note code drives a clock mux downstream.

Optional Feature:
Macro SFX_QUEUE_EN.
- Defined: a one-deep pending register holds the highest-priority ignored event received while busy (higher priority overwrites, lower is dropped). When the current sequence ends, the pending sequence starts on the following cycle, after one cycle of IDLE with note=0 and busy=0. Any preemption clears pending only if the pending event's priority is <= the new sequence's. Reset clears pending.
- Undefined: no pending register; ignored events are lost.

Decomposition:
- Package sfx_pkg:
  - note code constants (NOTE_SIL, NOTE_C, NOTE_D, NOTE_E, NOTE_G);
  - seq_id constants (SEQ_NONE, SEQ_PADDLE, SEQ_BRICK, SEQ_LOSE);
  - FSM state typedef;
  - per-sequence length constants.
- Sub-module sfx_note_rom: combinational lookup, (seq_id, idx[1:0]) -> (note[2:0], dur_ms[7:0], last). The sequencer holds FSM, counters, priority and queue.

Test Plan (TICK_DIV=4, GAP_MS=1):
- evt_paddle at t0: note=4 and busy=1 for cycles t0+1..t0+160; from t0+161 note=0, busy=0, seq_id=0.
- evt_brick: note=3 for 120 cycles, note=0 for 4 cycles, note=4 for 120 cycles, then idle; busy stays high for all 244 cycles.
- evt_paddle at cycle 50 of brick: ignored, brick completes unchanged. evt_lose at cycle 50 of brick: next cycle note=4 (G) and seq_id=3; full lose sequence = 320+4+320+4+320+4+640 cycles.
- evt_paddle, evt_brick and evt_lose in the same cycle: seq_id=3 and note=4 next cycle; no paddle or brick sound afterwards.
- Reset asserted during lose gap 2: note=0, busy=0, seq_id=0 immediately, without waiting for a clock edge. evt_brick one cycle after reset deasserts: brick plays normally.
- SFX_QUEUE_EN: evt_paddle during brick. Brick ends; after 1 idle cycle note=4 for 160 cycles. Without the macro, the bench checks for silence instead.
